// File: rtl/mvm_sequencer_if.sv
// Signal bundle between the MVM sequencer and its surroundings: job byte
// stream, A-FIFO write port, core control/data, and the result stream.
interface mvm_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MACS   = 8
);
  localparam int RES_WIDTH = 3 * DATA_WIDTH;
  localparam int IDX_WIDTH = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;

  logic                                job_start;
  logic                                in_valid;
  logic [DATA_WIDTH-1:0]               in_data;
  logic                                in_ready;
  logic [NUM_MACS-1:0]                 fifo_wren;
  logic [DATA_WIDTH-1:0]               fifo_wdata;
  logic [NUM_MACS-1:0]                 fifo_full;
  logic                                core_start;
  logic [DATA_WIDTH-1:0]               core_b_in;
  logic                                core_ready_b;
  logic                                core_done;
  logic [NUM_MACS-1:0][RES_WIDTH-1:0]  core_result;
  logic                                res_valid;
  logic [IDX_WIDTH-1:0]                res_idx;
  logic [RES_WIDTH-1:0]                res_data;
  logic                                res_ready;
  logic                                busy;

  // Sequencer side.
  modport master (
    input  job_start, in_valid, in_data, fifo_full, core_ready_b, core_done,
           core_result, res_ready,
    output in_ready, fifo_wren, fifo_wdata, core_start, core_b_in, res_valid,
           res_idx, res_data, busy
  );

  // Environment side (stream source, FIFOs, core, result sink).
  modport slave (
    output job_start, in_valid, in_data, fifo_full, core_ready_b, core_done,
           core_result, res_ready,
    input  in_ready, fifo_wren, fifo_wdata, core_start, core_b_in, res_valid,
           res_idx, res_data, busy
  );
endinterface

// File: rtl/mvm_sequencer.sv
// Job controller for the matrix-vector core: loads A rows into per-row FIFOs,
// buffers B, starts and feeds the core, then streams the captured results.
module mvm_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MACS   = 8
) (
  input logic             clk,
  input logic             rst,
  mvm_sequencer_if.master bus
);
  localparam int RES_WIDTH  = 3 * DATA_WIDTH;
  localparam int IDX_WIDTH  = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
  localparam int BCNT_WIDTH = $clog2(NUM_MACS + 1);
  localparam int WD_LIMIT   = 4 * NUM_MACS * NUM_MACS;
  localparam int WD_WIDTH   = $clog2(WD_LIMIT);

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_MACS - 1);
  localparam logic [BCNT_WIDTH-1:0] B_DONE   = BCNT_WIDTH'(NUM_MACS);
  localparam logic [WD_WIDTH-1:0]   WD_LAST  = WD_WIDTH'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_RUN, S_DRAIN
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  row, col, res_ptr;
  logic [BCNT_WIDTH-1:0] b_cnt;
  logic [WD_WIDTH-1:0]   wd_cnt;
  logic [DATA_WIDTH-1:0] b_buf   [NUM_MACS];
  logic [RES_WIDTH-1:0]  res_buf [NUM_MACS];
  logic                  err_to;
  logic                  accept;
  logic                  unused_err_to;

  assign accept = bus.in_valid && bus.in_ready;

  // err_to is a status bit with no port; this sink marks it as deliberately unobserved.
  assign unused_err_to = err_to;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; job_start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.job_start) state_nxt = S_LOAD_A;
      S_LOAD_A: if (accept && row == LAST_IDX && col == LAST_IDX) state_nxt = S_LOAD_B;
      S_LOAD_B: if (accept && col == LAST_IDX) state_nxt = S_START;
      S_START:  state_nxt = S_RUN;
      S_RUN: begin
        if (bus.core_done)         state_nxt = S_DRAIN;
        else if (wd_cnt == WD_LAST) state_nxt = S_IDLE;
      end
      S_DRAIN:  if (bus.res_ready && res_ptr == LAST_IDX) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: handshake strobes and data muxes follow the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    bus.in_ready   = 1'b0;
    bus.core_start = 1'b0;
    bus.core_b_in  = '0;
    bus.res_valid  = 1'b0;
    bus.res_idx    = '0;
    bus.res_data   = '0;
    bus.busy       = (state != S_IDLE);
    case (state)
      S_LOAD_A: bus.in_ready   = !bus.fifo_full[row];
      S_LOAD_B: bus.in_ready   = 1'b1;
      S_START:  bus.core_start = 1'b1;
      S_RUN:    if (b_cnt != B_DONE) bus.core_b_in = b_buf[b_cnt[IDX_WIDTH-1:0]];
      S_DRAIN: begin
        bus.res_valid = 1'b1;
        bus.res_idx   = res_ptr;
        bus.res_data  = res_buf[res_ptr];
      end
      default: ;
    endcase
  end

  // Datapath: load counters, FIFO write register, B/result buffers, watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      row            <= '0;
      col            <= '0;
      res_ptr        <= '0;
      b_cnt          <= '0;
      wd_cnt         <= '0;
      err_to         <= 1'b0;
      bus.fifo_wren  <= '0;
      bus.fifo_wdata <= '0;
      // NOTE: both buffers are small register arrays, so clearing them on reset is cheap and keeps a fresh job deterministic.
      for (int i = 0; i < NUM_MACS; i++) begin
        b_buf[i]   <= '0;
        res_buf[i] <= '0;
      end
    end else begin
      bus.fifo_wren <= '0;
      case (state)
        S_IDLE: begin
          row <= '0;
          col <= '0;
        end
        S_LOAD_A: if (accept) begin
          bus.fifo_wren  <= NUM_MACS'(1) << row;
          bus.fifo_wdata <= bus.in_data;
          if (col == LAST_IDX) begin
            col <= '0;
            row <= (row == LAST_IDX) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_LOAD_B: if (accept) begin
          b_buf[col] <= bus.in_data;
          col        <= (col == LAST_IDX) ? '0 : col + 1'b1;
        end
        S_START: begin
          b_cnt   <= '0;
          wd_cnt  <= '0;
          res_ptr <= '0;
        end
        S_RUN: begin
          if (bus.core_ready_b && b_cnt != B_DONE) b_cnt <= b_cnt + 1'b1;
          wd_cnt <= wd_cnt + 1'b1;
          if (bus.core_done) begin
            for (int i = 0; i < NUM_MACS; i++) res_buf[i] <= bus.core_result[i];
          end else if (wd_cnt == WD_LAST) begin
            err_to <= 1'b1;
          end
        end
        S_DRAIN: if (bus.res_ready) res_ptr <= (res_ptr == LAST_IDX) ? '0 : res_ptr + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer: emulated FIFOs and core, a matrix
// product reference model, and one monitor comparing outputs every cycle.
module tb_mvm_sequencer;
  localparam int NM = 8;

  typedef struct packed { logic [2:0] row; logic [7:0] data; } wr_item_t;
  typedef struct packed { logic [2:0] idx; logic [23:0] data; } res_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvm_sequencer_if #(.DATA_WIDTH(8), .NUM_MACS(NM)) bus ();
  mvm_sequencer #(.DATA_WIDTH(8), .NUM_MACS(NM)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int total = 0;
  int bad   = 0;
  int wr_total = 0;
  int wr_base  = 0;
  int bytes_sent = 0;
  bit withhold_done = 1'b0;
  bit res_mode = 1'b0;

  logic [7:0]  a_m [NM][NM];
  logic [7:0]  b_v [NM];
  logic [23:0] got_res [NM];
  wr_item_t    exp_wr [$];
  res_item_t   exp_res [$];

  logic [7:0] fifo_mem [NM][256];
  logic [7:0] fifo_wp [NM];
  logic [7:0] fifo_rp [NM];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: expected FIFO write order and A*B results.
  task automatic load_expect();
    wr_item_t w;
    res_item_t e;
    logic [23:0] acc;
    exp_wr.delete();
    exp_res.delete();
    for (int r = 0; r < NM; r++) begin
      acc = '0;
      for (int c = 0; c < NM; c++) begin
        w.row = 3'(r);
        w.data = a_m[r][c];
        exp_wr.push_back(w);
        acc = acc + 24'(a_m[r][c]) * 24'(b_v[c]);
      end
      e.idx = 3'(r);
      e.data = acc;
      exp_res.push_back(e);
    end
    wr_base = wr_total;
    bytes_sent = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    if (got) bytes_sent++;
    else check("send_accept", 64'(got), 64'd1);
  endtask

  task automatic send_a();
    for (int r = 0; r < NM; r++)
      for (int c = 0; c < NM; c++) send_byte(a_m[r][c]);
  endtask

  task automatic send_b(input int n);
    for (int k = 0; k < n; k++) send_byte(b_v[k]);
  endtask

  task automatic pulse_start();
    bus.job_start = 1'b1;
    @(posedge clk); #1;
    bus.job_start = 1'b0;
  endtask

  task automatic stall_row3();
    int n = 0;
    while (bytes_sent < 27 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.fifo_full = 8'h08;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.fifo_full = '0;
  endtask

  task automatic wait_core_start();
    int n = 0;
    @(negedge clk);
    while (!bus.core_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("core_start_seen", 64'(bus.core_start), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_res.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_beats_left", 64'(exp_res.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_job(input bit stall, input bit poke);
    load_expect();
    pulse_start();
    fork
      begin
        send_a();
        send_b(NM);
        bus.in_valid = 1'b0;
      end
      begin
        if (stall) stall_row3();
      end
    join
    if (poke) begin
      wait_core_start();
      @(posedge clk); #1;
      pulse_start();
    end
    wait_drain();
    check("write_count", 64'(wr_total - wr_base), 64'd64);
  endtask

  // Result sink: always ready, or alternating ready to exercise back-pressure.
  initial begin : res_sink
    int cyc = 0;
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.res_ready = (res_mode == 1'b0) ? 1'b1 : cyc[0];
    end
  end

  // Emulated core: takes B with gaps, multiplies against its FIFO rows, pulses done.
  initial begin : fake_core
    logic [7:0] b_got [$];
    bit active = 1'b0;
    int cyc = 0;
    logic [23:0] acc;
    bus.core_ready_b = 1'b0;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        for (int r = 0; r < NM; r++) fifo_rp[r] = '0;
      end else if (bus.core_start) begin
        active = 1'b1;
        b_got.delete();
        cyc = 0;
      end else if (active) begin
        if (bus.core_ready_b) b_got.push_back(bus.core_b_in);
        if (!bus.busy) active = 1'b0;
        cyc++;
      end
      @(posedge clk); #1;
      bus.core_done = 1'b0;
      bus.core_ready_b = 1'b0;
      bus.core_result = '0;
      if (active) begin
        if (b_got.size() < NM) begin
          bus.core_ready_b = ((cyc % 3) != 2);
        end else if (!withhold_done) begin
          for (int r = 0; r < NM; r++) begin
            check("core_fifo_fill", 64'(8'(fifo_wp[r] - fifo_rp[r])), 64'd8);
            acc = '0;
            for (int c = 0; c < NM; c++) begin
              acc = acc + 24'(fifo_mem[r][fifo_rp[r]]) * 24'(b_got[c]);
              fifo_rp[r] = fifo_rp[r] + 8'd1;
            end
            bus.core_result[r] = acc;
          end
          bus.core_done = 1'b1;
          active = 1'b0;
        end
      end
    end
  end

  // Monitor: compares FIFO writes, result beats and idle outputs every cycle.
  initial begin : monitor
    wr_item_t w;
    res_item_t e;
    bit prev_valid = 1'b0, prev_ready = 1'b0, prev_start = 1'b0, idle_next = 1'b0;
    logic [2:0] prev_idx = '0;
    logic [23:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int r = 0; r < NM; r++) fifo_wp[r] = '0;
        prev_valid = 1'b0;
        prev_start = 1'b0;
        idle_next = 1'b0;
      end else begin
        if (bus.fifo_wren != '0) begin
          wr_total++;
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 64'(bus.fifo_wren), 64'd0);
          end else begin
            w = exp_wr.pop_front();
            check("fifo_wren", 64'(bus.fifo_wren), 64'(8'd1 << w.row));
            check("fifo_wdata", 64'(bus.fifo_wdata), 64'(w.data));
          end
          for (int r = 0; r < NM; r++) begin
            if (bus.fifo_wren[r]) begin
              fifo_mem[r][fifo_wp[r]] = bus.fifo_wdata;
              fifo_wp[r] = fifo_wp[r] + 8'd1;
            end
          end
        end
        if (prev_start) check("core_start_pulse", 64'(bus.core_start), 64'd0);
        if (prev_valid && !prev_ready) begin
          check("stall_valid", 64'(bus.res_valid), 64'd1);
          check("stall_idx", 64'(bus.res_idx), 64'(prev_idx));
          check("stall_data", 64'(bus.res_data), 64'(prev_data));
        end
        if (idle_next) begin
          check("busy_after_drain", 64'(bus.busy), 64'd0);
          idle_next = 1'b0;
        end
        if (bus.res_valid && bus.res_ready) begin
          got_res[bus.res_idx] = bus.res_data;
          if (exp_res.size() == 0) begin
            check("unexpected_beat", 64'(bus.res_valid), 64'd0);
          end else begin
            e = exp_res.pop_front();
            check("res_idx", 64'(bus.res_idx), 64'(e.idx));
            check("res_data", 64'(bus.res_data), 64'(e.data));
            if (exp_res.size() == 0) idle_next = 1'b1;
          end
        end
        if (!bus.busy) begin
          check("idle_in_ready", 64'(bus.in_ready), 64'd0);
          check("idle_res_valid", 64'(bus.res_valid), 64'd0);
        end
        prev_valid = bus.res_valid;
        prev_ready = bus.res_ready;
        prev_idx = bus.res_idx;
        prev_data = bus.res_data;
        prev_start = bus.core_start;
      end
    end
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n;
    bus.job_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.fifo_full = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_fifo_wren", 64'(bus.fifo_wren), 64'd0);
    check("rst_fifo_wdata", 64'(bus.fifo_wdata), 64'd0);
    check("rst_core_start", 64'(bus.core_start), 64'd0);
    check("rst_core_b_in", 64'(bus.core_b_in), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_idx", 64'(bus.res_idx), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err_to", 64'(dut.err_to), 64'd0);
    @(posedge clk); #1;

    // Identity A, B = 1..8.
    for (int r = 0; r < NM; r++) begin
      for (int c = 0; c < NM; c++) a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
      b_v[r] = 8'(r + 1);
    end
    run_job(1'b0, 1'b0);
    for (int r = 0; r < NM; r++) check("identity_result", 64'(got_res[r]), 64'(r + 1));

    // All 0xFF: 8 * 0xFE01 per row.
    for (int r = 0; r < NM; r++) begin
      for (int c = 0; c < NM; c++) a_m[r][c] = 8'hFF;
      b_v[r] = 8'hFF;
    end
    @(posedge clk); #1;
    run_job(1'b0, 1'b0);
    for (int r = 0; r < NM; r++) check("allff_result", 64'(got_res[r]), 64'h07F008);

    // FIFO 3 full for 5 cycles mid row 3.
    for (int r = 0; r < NM; r++)
      for (int c = 0; c < NM; c++) a_m[r][c] = 8'(r * 8 + c + 1);
    b_v = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    @(posedge clk); #1;
    run_job(1'b1, 1'b0);

    // Result back-pressure.
    for (int r = 0; r < NM; r++) begin
      for (int c = 0; c < NM; c++) a_m[r][c] = 8'((r * 37 + c * 11) ^ 8'h5A);
      b_v[r] = 8'(200 - r * 13);
    end
    res_mode = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, 1'b0);
    res_mode = 1'b0;

    // job_start during RUN is ignored.
    for (int r = 0; r < NM; r++) begin
      for (int c = 0; c < NM; c++) a_m[r][c] = 8'(r + c);
      b_v[r] = 8'(r * 2 + 1);
    end
    @(posedge clk); #1;
    run_job(1'b0, 1'b1);

    // Reset during LOAD_B aborts the job.
    @(posedge clk); #1;
    load_expect();
    pulse_start();
    send_a();
    send_b(3);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_fifo_wren", 64'(bus.fifo_wren), 64'd0);
    exp_res.delete();
    exp_wr.delete();
    @(posedge clk); #1;

    // Fresh job after the abort.
    for (int r = 0; r < NM; r++) begin
      for (int c = 0; c < NM; c++) a_m[r][c] = 8'(255 - r * c);
      b_v[r] = 8'(r + 17);
    end
    run_job(1'b0, 1'b0);

    // Watchdog: core_done withheld.
    withhold_done = 1'b1;
    @(posedge clk); #1;
    load_expect();
    pulse_start();
    send_a();
    send_b(NM);
    bus.in_valid = 1'b0;
    wait_core_start();
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    check("watchdog_run_cycles", 64'(n), 64'd256);
    check("watchdog_err_to", 64'(dut.err_to), 64'd1);
    check("watchdog_write_count", 64'(wr_total - wr_base), 64'd64);
    exp_res.delete();
    withhold_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
